csr_mem_bridge: RTL and testbench

// Parametrised CSR block with a forwarded memory window, for use behind the host register bus.
// - Holds NUM_REGS read/write registers with byte-strobe writes.
// - Forwards accesses in a memory window to an external RAM/ROM using a req/ready handshake.
// - Responds with an error on decode faults and on memory timeouts.

---
 rtl/csr_mem_bridge.sv | 136 +++++++++++++
 tb/tb_csr_mem_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mem_bridge.sv
// Host register-bus target: a bank of byte-writable CSRs plus a word-aligned
// window forwarded to an external RAM/ROM over a req/ready handshake with timeout.
module csr_mem_bridge #(
  parameter int unsigned       DATA_W    = 32,
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter logic [ADDR_W-1:0] MEM_BASE  = 'h40,
  parameter int unsigned       MEM_DEPTH = 32,
  parameter int unsigned       TIMEOUT   = 16,
  localparam int unsigned      STRB_W    = DATA_W / 8,
  localparam int unsigned      MEM_AW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic [ADDR_W-1:0]            host_addr,
  input  logic                         host_re,
  input  logic                         host_we,
  input  logic [DATA_W-1:0]            host_wdata,
  input  logic [STRB_W-1:0]            host_wstrb,
  output logic [DATA_W-1:0]            host_rdata,
  output logic                         host_ready,
  output logic                         host_err,
  output logic [NUM_REGS*DATA_W-1:0]   regs_q,
  output logic                         mem_req,
  output logic                         mem_we,
  output logic [MEM_AW-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [STRB_W-1:0]            mem_wstrb,
  input  logic [DATA_W-1:0]            mem_rdata,
  input  logic                         mem_ready
);

  localparam int unsigned      IDX_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int unsigned      CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned      AW1     = ADDR_W + 1;
  localparam logic [AW1-1:0]   CSR_END = AW1'(4 * NUM_REGS);
  localparam logic [AW1-1:0]   WIN_LO  = AW1'(MEM_BASE);
  localparam logic [AW1-1:0]   WIN_HI  = AW1'(MEM_BASE) + AW1'(4 * MEM_DEPTH);

  typedef enum logic [2:0] {IDLE, REG_RESP, MEM_REQ, MEM_WAIT, RESP} state_e;

  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] csr_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] csr_d;
  logic [AW1-1:0]                  addr_x;
  logic                            req;
  logic                            csr_hit;
  logic                            win_hit;
  logic                            dec_err;
  logic [IDX_W-1:0]                csr_idx;
  logic [MEM_AW-1:0]               win_idx;

  assign regs_q = csr_q;

  // Address decode (extended by one bit so the window end cannot wrap) and CSR byte merge
  always_comb begin
    addr_x  = {1'b0, host_addr};
    req     = host_re | host_we;
    csr_hit = addr_x < CSR_END;
    win_hit = (addr_x >= WIN_LO) && (addr_x < WIN_HI);
    dec_err = (host_re & host_we) | (|host_addr[1:0]) | ~(csr_hit | win_hit);
    csr_idx = IDX_W'(host_addr >> 2);
    win_idx = MEM_AW'((host_addr - MEM_BASE) >> 2);
    csr_d   = csr_q;
    for (int j = 0; j < STRB_W; j++) begin
      if (host_wstrb[j]) csr_d[csr_idx][8*j +: 8] = host_wdata[8*j +: 8];
    end
  end

  // Control FSM; host-side response outputs default low so they only pulse
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      csr_q      <= {NUM_REGS{RESET_VAL}};
      host_rdata <= '0;
      host_ready <= 1'b0;
      host_err   <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
    end else begin
      host_rdata <= '0;
      host_ready <= 1'b0;
      host_err   <= 1'b0;
      mem_req    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req) begin
            if (dec_err) begin
              state_q    <= REG_RESP;
              host_ready <= 1'b1;
              host_err   <= 1'b1;
            end else if (csr_hit) begin
              state_q    <= REG_RESP;
              host_ready <= 1'b1;
              if (host_we) csr_q      <= csr_d;
              else         host_rdata <= csr_q[csr_idx];
            end else begin
              state_q   <= MEM_REQ;
              mem_req   <= 1'b1;
              mem_we    <= host_we;
              mem_addr  <= win_idx;
              mem_wdata <= host_wdata;
              mem_wstrb <= host_wstrb;
            end
          end
        end
        REG_RESP, RESP: state_q <= IDLE;
        // mem_ready is honoured in the request cycle too, skipping the wait state
        MEM_REQ, MEM_WAIT: begin
          if (mem_ready) begin
            state_q    <= RESP;
            host_ready <= 1'b1;
            host_rdata <= mem_we ? '0 : mem_rdata;
          end else if (state_q == MEM_REQ) begin
            state_q <= MEM_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            state_q    <= RESP;
            host_ready <= 1'b1;
            host_err   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_mem_bridge.sv
// Randomised bench for csr_mem_bridge: a behavioural CSR/memory model predicts
// every host response while a bench-side RAM answers the memory handshake.
module tb_csr_mem_bridge;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned NUM_REGS  = 4;
  localparam int unsigned MEM_DEPTH = 32;
  localparam int unsigned TIMEOUT   = 16;
  localparam int unsigned STRB_W    = DATA_W / 8;
  localparam int unsigned MEM_AW    = $clog2(MEM_DEPTH);
  localparam logic [DATA_W-1:0] RESET_VAL = 32'hA5A5_0F0F;
  localparam logic [ADDR_W-1:0] MEM_BASE  = 32'h40;

  logic                       clk;
  logic                       rst_b;
  logic [ADDR_W-1:0]          host_addr;
  logic                       host_re;
  logic                       host_we;
  logic [DATA_W-1:0]          host_wdata;
  logic [STRB_W-1:0]          host_wstrb;
  logic [DATA_W-1:0]          host_rdata;
  logic                       host_ready;
  logic                       host_err;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic                       mem_req;
  logic                       mem_we;
  logic [MEM_AW-1:0]          mem_addr;
  logic [DATA_W-1:0]          mem_wdata;
  logic [STRB_W-1:0]          mem_wstrb;
  logic [DATA_W-1:0]          mem_rdata;
  logic                       mem_ready;

  csr_mem_bridge #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL),
    .MEM_BASE(MEM_BASE), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_b(rst_b),
    .host_addr(host_addr), .host_re(host_re), .host_we(host_we),
    .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .host_rdata(host_rdata), .host_ready(host_ready), .host_err(host_err),
    .regs_q(regs_q),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk  = 0;
  int n_pass = 0;
  int txn    = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s (txn %0d): got 0x%0h expected 0x%0h", tag, txn, got, exp);
  endtask

  function automatic logic [DATA_W-1:0] init_word(input int i);
    return 32'hC0DE_0000 ^ (i * 32'h9E37_79B1);
  endfunction

  // Reference model state
  logic [DATA_W-1:0] ref_regs [NUM_REGS];
  logic [DATA_W-1:0] ref_mem  [MEM_DEPTH];

  // Monitors: pulse counters and idle-output cleanliness
  int rdy_cnt  = 0;
  int req_cnt  = 0;
  int idle_bad = 0;
  always @(negedge clk) begin
    if (host_ready === 1'b1) rdy_cnt++;
    else if (host_err !== 1'b0 || host_rdata !== '0) idle_bad++;
    if (mem_req === 1'b1) req_cnt++;
  end

  // Memory responder with its own RAM contents
  logic [DATA_W-1:0] ram [MEM_DEPTH];
  bit                rsp_en    = 1'b1;
  int                rsp_delay = 0;
  bit                rsp_busy;
  bit                rsp_stable;
  logic [MEM_AW-1:0] cap_addr;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata;
  logic [STRB_W-1:0] cap_wstrb;

  initial begin : responder
    mem_ready = 1'b0;
    mem_rdata = '0;
    rsp_busy  = 1'b0;
    rsp_stable = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) ram[i] = init_word(i);
    forever begin
      @(posedge clk); #1;
      if (mem_req === 1'b1) begin
        cap_addr  = mem_addr;
        cap_we    = mem_we;
        cap_wdata = mem_wdata;
        cap_wstrb = mem_wstrb;
        if (rsp_en) begin
          rsp_busy = 1'b1;
          repeat (rsp_delay) begin @(posedge clk); #1; end
          rsp_stable = (mem_addr === cap_addr) && (mem_we === cap_we) &&
                       (mem_wdata === cap_wdata) && (mem_wstrb === cap_wstrb);
          if (mem_we) begin
            for (int j = 0; j < STRB_W; j++)
              if (mem_wstrb[j]) ram[mem_addr][8*j +: 8] = mem_wdata[8*j +: 8];
            mem_rdata = $urandom;
          end else begin
            mem_rdata = ram[mem_addr];
          end
          mem_ready = 1'b1;
          @(posedge clk); #1;
          mem_ready = 1'b0;
          mem_rdata = $urandom;
          rsp_busy  = 1'b0;
        end
      end
    end
  end

  function automatic logic [DATA_W-1:0] strb_mask(input logic [STRB_W-1:0] st);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int b = 0; b < STRB_W; b++) if (st[b]) m = m | (32'hFF << (8 * b));
    return m;
  endfunction

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check_eq(tag, 64'(regs_q[i*DATA_W +: DATA_W]), 64'(ref_regs[i]));
  endtask

  // One host transaction: predict, drive, measure latency, compare everything
  task automatic access(input bit re, input bit we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [STRB_W-1:0] st,
                        input int dly, input bit stall, output logic [DATA_W-1:0] rd);
    longint unsigned   a;
    bit                is_err, is_mem, timed_out;
    int                idx, exp_lat, lat, rb, qb, guard;
    logic [DATA_W-1:0] exp_rd, m;
    logic              got_err;

    txn++;
    a = addr;
    is_err = 1'b0; is_mem = 1'b0; timed_out = 1'b0;
    exp_rd = '0; exp_lat = 1; idx = 0;
    if ((re && we) || (a % 4) != 0) is_err = 1'b1;
    else if (a < 4 * NUM_REGS) idx = int'(a / 4);
    else if (a >= MEM_BASE && a < MEM_BASE + 4 * MEM_DEPTH) begin
      is_mem = 1'b1;
      idx = int'((a - MEM_BASE) / 4);
    end else is_err = 1'b1;

    if (!is_err && !is_mem) begin
      m = strb_mask(st);
      if (we) ref_regs[idx] = (ref_regs[idx] & ~m) | (wd & m);
      else    exp_rd = ref_regs[idx];
    end else if (is_mem) begin
      timed_out = stall || (dly > TIMEOUT);
      if (timed_out) begin
        exp_lat = TIMEOUT + 2;
      end else begin
        exp_lat = 2 + dly;
        m = strb_mask(st);
        if (we) ref_mem[idx] = (ref_mem[idx] & ~m) | (wd & m);
        else    exp_rd = ref_mem[idx];
      end
    end

    rsp_en = !stall;
    rsp_delay = dly;
    rb = rdy_cnt;
    qb = req_cnt;
    host_re = re; host_we = we; host_addr = addr; host_wdata = wd; host_wstrb = st;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (host_ready !== 1'b1 && lat < 60);
    got_err = host_err;
    rd = host_rdata;
    host_re = 1'b0; host_we = 1'b0;
    guard = 0;
    while (rsp_busy && guard < 100) begin @(posedge clk); #1; guard++; end
    repeat (2) begin @(posedge clk); #1; end

    check_eq("latency", 64'(lat), 64'(exp_lat));
    check_eq("err", 64'(got_err), 64'(is_err || timed_out));
    check_eq("rdata", 64'(rd), 64'(exp_rd));
    check_eq("ready_pulses", 64'(rdy_cnt - rb), 64'd1);
    check_eq("mem_req_cycles", 64'(req_cnt - qb), 64'(is_mem));
    if (is_mem) begin
      check_eq("mem_addr", 64'(cap_addr), 64'(idx));
      check_eq("mem_we", 64'(cap_we), 64'(we));
      if (we) begin
        check_eq("mem_wdata", 64'(cap_wdata), 64'(wd));
        check_eq("mem_wstrb", 64'(cap_wstrb), 64'(st));
      end
      if (!stall) check_eq("mem_hold", 64'(rsp_stable), 64'd1);
    end
    check_regs("regs");
    rsp_en = 1'b1;
  endtask

  logic [DATA_W-1:0] rd;
  int                op, dly, sel, rb;
  bit                re, we, stall;
  logic [ADDR_W-1:0] addr;

  initial begin
    rst_b = 1'b0;
    host_re = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; host_wstrb = '0;
    for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = RESET_VAL;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = init_word(i);

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_host_ready", 64'(host_ready), 64'd0);
    check_eq("rst_host_err", 64'(host_err), 64'd0);
    check_eq("rst_host_rdata", 64'(host_rdata), 64'd0);
    check_eq("rst_mem_req", 64'(mem_req), 64'd0);
    check_eq("rst_mem_we", 64'(mem_we), 64'd0);
    check_eq("rst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    check_eq("rst_mem_wstrb", 64'(mem_wstrb), 64'd0);
    check_regs("rst_regs");
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Directed: CSR write/read, byte strobes
    access(1'b0, 1'b1, 32'h4, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd);
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, rd);
    check_eq("csr_rd_const", 64'(rd), 64'hDEAD_BEEF);
    access(1'b0, 1'b1, 32'h0, 32'h1122_3344, 4'hF, 0, 1'b0, rd);
    access(1'b0, 1'b1, 32'h0, 32'hAABB_CCDD, 4'b0101, 0, 1'b0, rd);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0, rd);
    check_eq("strb_rd_const", 64'(rd), 64'h11BB_33DD);

    // Directed: memory write then read at 0x48, response 3 cycles after request
    access(1'b0, 1'b1, 32'h48, 32'h0BAD_F00D, 4'hF, 3, 1'b0, rd);
    check_eq("mem_idx_const", 64'(cap_addr), 64'd2);
    access(1'b1, 1'b0, 32'h48, 32'h0, 4'h0, 3, 1'b0, rd);
    check_eq("mem_rd_const", 64'(rd), 64'h0BAD_F00D);
    // Same-cycle ready, and timeout with no ready
    access(1'b1, 1'b0, 32'h44, 32'h0, 4'h0, 0, 1'b0, rd);
    access(1'b1, 1'b0, 32'h4C, 32'h0, 4'h0, 0, 1'b1, rd);
    // Late response after timeout must be ignored
    access(1'b1, 1'b0, 32'h50, 32'h0, 4'h0, TIMEOUT + 2, 1'b0, rd);

    // Directed errors
    access(1'b0, 1'b1, 32'h30, 32'h1234_5678, 4'hF, 0, 1'b0, rd);
    access(1'b0, 1'b1, 32'h2, 32'h1234_5678, 4'hF, 0, 1'b0, rd);
    access(1'b1, 1'b1, 32'h4, 32'h1234_5678, 4'hF, 0, 1'b0, rd);
    access(1'b1, 1'b1, 32'h48, 32'h1234_5678, 4'hF, 0, 1'b0, rd);
    access(1'b1, 1'b0, MEM_BASE + 4 * MEM_DEPTH, 32'h0, 4'h0, 0, 1'b0, rd);

    // Randomised traffic
    for (int n = 0; n < 150; n++) begin
      op = $urandom_range(0, 9);
      we = $urandom_range(0, 1);
      re = !we;
      dly = $urandom_range(0, 4);
      stall = 1'b0;
      sel = $urandom_range(0, 19);
      case (op)
        0, 1, 2: addr = 4 * $urandom_range(0, NUM_REGS - 1);
        3, 4, 5, 6: begin
          addr = MEM_BASE + 4 * $urandom_range(0, MEM_DEPTH - 1);
          if (sel == 0) stall = 1'b1;
          else if (sel == 1) begin
            re = 1'b1; we = 1'b0;
            dly = $urandom_range(TIMEOUT + 1, TIMEOUT + 3);
          end
        end
        7: addr = 4 * $urandom_range(0, NUM_REGS + MEM_DEPTH) + $urandom_range(1, 3);
        8: begin
          if (sel < 7)       addr = 4 * $urandom_range(NUM_REGS, MEM_BASE / 4 - 1);
          else if (sel < 14) addr = MEM_BASE + 4 * MEM_DEPTH + 4 * $urandom_range(0, 15);
          else               addr = ($urandom | 32'h8000_0000) & 32'hFFFF_FFFC;
        end
        default: begin
          re = 1'b1; we = 1'b1;
          addr = 4 * $urandom_range(0, NUM_REGS - 1);
        end
      endcase
      access(re, we, addr, $urandom, STRB_W'($urandom), dly, stall, rd);
    end

    // Reset in the middle of a memory wait
    txn++;
    rsp_en = 1'b0;
    rb = rdy_cnt;
    host_re = 1'b1; host_we = 1'b0; host_addr = MEM_BASE + 8;
    repeat (5) begin @(posedge clk); #1; end
    check_eq("pre_rst_mem_addr", 64'(mem_addr), 64'd2);
    rst_b = 1'b0;
    host_re = 1'b0;
    #2;
    check_eq("midrst_host_ready", 64'(host_ready), 64'd0);
    check_eq("midrst_mem_addr", 64'(mem_addr), 64'd0);
    check_eq("midrst_mem_req", 64'(mem_req), 64'd0);
    for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = RESET_VAL;
    check_regs("midrst_regs");
    @(posedge clk); #1;
    rst_b = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check_eq("midrst_no_ready", 64'(rdy_cnt - rb), 64'd0);
    rsp_en = 1'b1;
    access(1'b1, 1'b0, 32'h4, 32'h0, 4'h0, 0, 1'b0, rd);
    check_eq("post_rst_csr", 64'(rd), 64'(RESET_VAL));

    check_eq("idle_outputs_zero", 64'(idle_bad), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
